// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package div_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } div_state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/signed_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module signed_divider_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, dvs_i};
    // A clear sign bit means the trial subtraction did not underflow.
    q_o     = ~diff[WIDTH+1];
    rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider: magnitudes are divided MSB-first, signs are applied at the end.
module signed_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dvz_q, dvz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;

  signed_divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (prem_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    prem_d        = prem_q;
    quo_d         = quo_q;
    in1_d         = in1_q;
    qneg_d        = qneg_q;
    rneg_d        = rneg_q;
    dvz_d         = dvz_q;
    quot_d        = quot_q;
    rem_d         = rem_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    div_by_zero_d = div_by_zero_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          in1_d   = in1;
          // Magnitude of the most negative value wraps to itself, which is correct unsigned.
          dvd_d   = in1[WIDTH-1] ? (~in1 + 1'b1) : in1;
          dvs_d   = in2[WIDTH-1] ? (~in2 + 1'b1) : in2;
          prem_d  = '0;
          quo_d   = '0;
          qneg_d  = in1[WIDTH-1] ^ in2[WIDTH-1];
          rneg_d  = in1[WIDTH-1];
          dvz_d   = (in2 == '0);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        prem_d = step_rem;
        quo_d  = {quo_q[WIDTH-2:0], step_q};
        dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (dvz_q) begin
          quot_d = '1;
          rem_d  = in1_q;
        end else begin
          quot_d = qneg_q ? (~quo_q + 1'b1) : quo_q;
          rem_d  = rneg_q ? (~prem_q[WIDTH-1:0] + 1'b1) : prem_q[WIDTH-1:0];
        end
        div_by_zero_d = dvz_q;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      prem_q        <= '0;
      quo_q         <= '0;
      in1_q         <= '0;
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
      dvz_q         <= 1'b0;
      quot_q        <= '0;
      rem_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      prem_q        <= prem_d;
      quo_q         <= quo_d;
      in1_q         <= in1_d;
      qneg_q        <= qneg_d;
      rneg_q        <= rneg_d;
      dvz_q         <= dvz_d;
      quot_q        <= quot_d;
      rem_q         <= rem_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;

endmodule
